// File: rtl/lcd_timing_gen.sv
// Single-clock LCD/VGA timing generator with latency-matched panel outputs.
// Build macro LCD_TIMING_PATTERN_EN adds an internal test-pattern source selected by pat_sel_i.
`timescale 1ns/1ps
module lcd_timing_gen #(
  parameter int unsigned H_ACTIVE  = 480,
  parameter int unsigned H_FP      = 2,
  parameter int unsigned H_SYNC    = 41,
  parameter int unsigned H_BP      = 2,
  parameter int unsigned V_ACTIVE  = 272,
  parameter int unsigned V_FP      = 2,
  parameter int unsigned V_SYNC    = 10,
  parameter int unsigned V_BP      = 2,
  parameter bit          HS_POL    = 1'b0,
  parameter bit          VS_POL    = 1'b0,
  parameter int unsigned PIX_LAT   = 1,
  parameter int unsigned TILE_LOG2 = 3,
  parameter int unsigned BAR_LOG2  = 6
) (
  input  logic                        pxclk_i,
  input  logic                        rst_i,
  input  logic [1:0]                  pat_sel_i,
  input  logic [15:0]                 rgb_i,
  output logic [$clog2(H_ACTIVE)-1:0] col_o,
  output logic [$clog2(V_ACTIVE)-1:0] lin_o,
  output logic                        active_o,
  output logic                        sof_o,
  output logic                        sol_o,
  output logic                        lcd_hsync_o,
  output logic                        lcd_vsync_o,
  output logic                        lcd_den_o,
  output logic [15:0]                 lcd_rgb_o
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW       = $clog2(H_TOTAL);
  localparam int unsigned VW       = $clog2(V_TOTAL);
  localparam int unsigned CW       = $clog2(H_ACTIVE);
  localparam int unsigned LW       = $clog2(V_ACTIVE);
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = V_ACTIVE + V_FP + V_SYNC;

  if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_porch
    $error("lcd_timing_gen: porch and sync widths must be at least 1");
  end
  if (PIX_LAT > 4) begin : g_bad_lat
    $error("lcd_timing_gen: PIX_LAT must be in 0..4");
  end

  // Payload carried through the pixel-source latency pipe
  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        den;
`ifdef LCD_TIMING_PATTERN_EN
    logic        use_pat;
    logic [15:0] pat;
`endif
  } pipe_t;

  localparam pipe_t PIPE_IDLE = '{hs: ~HS_POL, vs: ~VS_POL, default: '0};

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic          h_last;
  logic          v_last;
  logic          in_active;
  logic          h_sync;
  logic          v_sync;
  logic          hs_s;
  logic          vs_s;
  pipe_t         pipe_in;
  pipe_t         pipe_out;
  logic [15:0]   pix;

  always_comb begin
    h_last    = (hcnt == HW'(H_TOTAL - 1));
    v_last    = (vcnt == VW'(V_TOTAL - 1));
    in_active = (hcnt < HW'(H_ACTIVE)) && (vcnt < VW'(V_ACTIVE));
    h_sync    = (hcnt >= HW'(HS_START)) && (hcnt < HW'(HS_END));
    v_sync    = (vcnt >= VW'(VS_START)) && (vcnt < VW'(VS_END));
  end

  // vcnt only moves on the hcnt wrap, so vsync edges stay line-aligned
  always_ff @(posedge pxclk_i) begin
    if (rst_i) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (h_last) begin
      hcnt <= '0;
      vcnt <= v_last ? '0 : vcnt + VW'(1);
    end else begin
      hcnt <= hcnt + HW'(1);
    end
  end

  always_ff @(posedge pxclk_i) begin
    if (rst_i) begin
      col_o    <= '0;
      lin_o    <= '0;
      active_o <= 1'b0;
      sof_o    <= 1'b0;
      sol_o    <= 1'b0;
      hs_s     <= ~HS_POL;
      vs_s     <= ~VS_POL;
    end else begin
      col_o    <= in_active ? CW'(hcnt) : '0;
      lin_o    <= in_active ? LW'(vcnt) : '0;
      active_o <= in_active;
      sof_o    <= (hcnt == '0) && (vcnt == '0);
      sol_o    <= (hcnt == '0);
      hs_s     <= h_sync ? HS_POL : ~HS_POL;
      vs_s     <= v_sync ? VS_POL : ~VS_POL;
    end
  end

`ifdef LCD_TIMING_PATTERN_EN
  localparam logic [31:0] TILE_MASK = 32'((64'd1 << TILE_LOG2) - 64'd1);

  logic [1:0]  pat_q;
  logic [15:0] pat_pix;
  logic [2:0]  bar_idx;
  logic        tile_c;
  logic        tile_l;
  logic        grid_c;
  logic        grid_l;

  // Selection latched on the frame-start count so changes land on the next frame
  always_ff @(posedge pxclk_i) begin
    if (rst_i) begin
      pat_q <= 2'd0;
    end else if ((hcnt == '0) && (vcnt == '0)) begin
      pat_q <= pat_sel_i;
    end
  end

  always_comb begin
    tile_c  = 1'(32'(col_o) >> TILE_LOG2);
    tile_l  = 1'(32'(lin_o) >> TILE_LOG2);
    grid_c  = ((32'(col_o) & TILE_MASK) == 32'd0);
    grid_l  = ((32'(lin_o) & TILE_MASK) == 32'd0);
    bar_idx = 3'(32'(col_o) >> BAR_LOG2);
    pat_pix = 16'h0000;
    case (pat_q)
      2'd1:    pat_pix = (tile_c ^ tile_l) ? 16'h0000 : 16'hFFFF;
      2'd2:    pat_pix = {{5{bar_idx[2]}}, {6{bar_idx[1]}}, {5{bar_idx[0]}}};
      2'd3:    pat_pix = (grid_c || grid_l) ? 16'hFFFF : 16'h0000;
      default: pat_pix = 16'h0000;
    endcase
  end
`else
  logic cfg_unused;
  assign cfg_unused = ^{pat_sel_i, 8'(TILE_LOG2), 8'(BAR_LOG2)};
`endif

  always_comb begin
    pipe_in     = PIPE_IDLE;
    pipe_in.hs  = hs_s;
    pipe_in.vs  = vs_s;
    pipe_in.den = active_o;
`ifdef LCD_TIMING_PATTERN_EN
    pipe_in.use_pat = (pat_q != 2'd0);
    pipe_in.pat     = pat_pix;
`endif
  end

  // Delay sync/den by the pixel-source latency so they line up with rgb_i
  if (PIX_LAT == 0) begin : g_no_lat
    assign pipe_out = pipe_in;
  end else begin : g_lat
    pipe_t dly_q [PIX_LAT];
    always_ff @(posedge pxclk_i) begin
      if (rst_i) begin
        for (int i = 0; i < PIX_LAT; i++) dly_q[i] <= PIPE_IDLE;
      end else begin
        dly_q[0] <= pipe_in;
        for (int i = 1; i < PIX_LAT; i++) dly_q[i] <= dly_q[i-1];
      end
    end
    assign pipe_out = dly_q[PIX_LAT-1];
  end

  always_comb begin
    pix = rgb_i;
`ifdef LCD_TIMING_PATTERN_EN
    if (pipe_out.use_pat) pix = pipe_out.pat;
`endif
  end

  always_ff @(posedge pxclk_i) begin
    if (rst_i) begin
      lcd_hsync_o <= ~HS_POL;
      lcd_vsync_o <= ~VS_POL;
      lcd_den_o   <= 1'b0;
      lcd_rgb_o   <= 16'h0000;
    end else begin
      lcd_hsync_o <= pipe_out.hs;
      lcd_vsync_o <= pipe_out.vs;
      lcd_den_o   <= pipe_out.den;
      lcd_rgb_o   <= pipe_out.den ? pix : 16'h0000;
    end
  end

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Self-checking bench for lcd_timing_gen: reference timing model, spot-vector table and rgb scoreboard.
`timescale 1ns/1ps
module tb_lcd_timing_gen;

  localparam int HA = 8, HF = 2, HSW = 3, HB = 1;
  localparam int VA = 4, VF = 1, VSW = 2, VB = 1;
  localparam int HT = HA + HF + HSW + HB;
  localparam int VT = VA + VF + VSW + VB;
  localparam int FT = HT * VT;
  localparam int LAT = 1;
`ifdef LCD_TIMING_PATTERN_EN
  localparam bit PAT_EN = 1'b1;
`else
  localparam bit PAT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  pat_sel = 2'd0;
  logic [15:0] rgb = 16'h0;
  logic [15:0] rgb_zero = 16'h0;

  logic [2:0]  col;
  logic [1:0]  lin;
  logic        act, sof, sol, hs, vs, den;
  logic [15:0] lcd_rgb;

  logic [2:0]  l0_col_unused, l3_col_unused;
  logic [1:0]  l0_lin_unused, l3_lin_unused;
  logic        l0_act, l0_sof_unused, l0_sol_unused, l0_hs_unused, l0_vs_unused, l0_den;
  logic        l3_act, l3_sof_unused, l3_sol_unused, l3_hs_unused, l3_vs_unused, l3_den;
  logic [15:0] l0_rgb_unused, l3_rgb_unused;

  always #5 clk = ~clk;

  lcd_timing_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
                   .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
                   .HS_POL(1'b0), .VS_POL(1'b0), .PIX_LAT(LAT), .TILE_LOG2(1), .BAR_LOG2(1)) u_dut (
    .pxclk_i(clk), .rst_i(rst), .pat_sel_i(pat_sel), .rgb_i(rgb),
    .col_o(col), .lin_o(lin), .active_o(act), .sof_o(sof), .sol_o(sol),
    .lcd_hsync_o(hs), .lcd_vsync_o(vs), .lcd_den_o(den), .lcd_rgb_o(lcd_rgb));

  lcd_timing_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
                   .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB), .PIX_LAT(0)) u_lat0 (
    .pxclk_i(clk), .rst_i(rst), .pat_sel_i(2'd0), .rgb_i(rgb_zero),
    .col_o(l0_col_unused), .lin_o(l0_lin_unused), .active_o(l0_act), .sof_o(l0_sof_unused),
    .sol_o(l0_sol_unused), .lcd_hsync_o(l0_hs_unused), .lcd_vsync_o(l0_vs_unused),
    .lcd_den_o(l0_den), .lcd_rgb_o(l0_rgb_unused));

  lcd_timing_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
                   .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB), .PIX_LAT(3)) u_lat3 (
    .pxclk_i(clk), .rst_i(rst), .pat_sel_i(2'd0), .rgb_i(rgb_zero),
    .col_o(l3_col_unused), .lin_o(l3_lin_unused), .active_o(l3_act), .sof_o(l3_sof_unused),
    .sol_o(l3_sol_unused), .lcd_hsync_o(l3_hs_unused), .lcd_vsync_o(l3_vs_unused),
    .lcd_den_o(l3_den), .lcd_rgb_o(l3_rgb_unused));

  typedef struct {
    int k;
    int col, lin;
    bit act, sof, sol, hs, vs, den;
  } vec_t;
  vec_t vt[10];

  int n_checks = 0;
  int n_fail = 0;
  int k = 0;
  int frame_pat = 0;
  int last_sof = -1, last_sol = -1;
  int last_act0 = 0, last_act3 = 0;
  bit p_act0 = 0, p_den0 = 0, p_act3 = 0, p_den3 = 0;
  bit win = 0, cap_on = 0;
  int hs_low = 0, vs_low = 0, den_hi = 0, sof_cnt = 0, sol_cnt = 0;
  logic [15:0] prev_word = 16'h0;
  logic [15:0] sb[$];
  logic [15:0] cap[$];

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s at k=%0d: got %0h, expected %0h", name, k, actual, expected);
    end
  endtask

  function automatic int mh(input int n); return n % HT; endfunction
  function automatic int mv(input int n); return (n / HT) % VT; endfunction
  function automatic bit m_act(input int n);
    return (n >= 0) && (mh(n) < HA) && (mv(n) < VA);
  endfunction
  function automatic bit m_hs(input int n);
    if (n < 0) return 1'b1;
    return !((mh(n) >= HA + HF) && (mh(n) < HA + HF + HSW));
  endfunction
  function automatic bit m_vs(input int n);
    if (n < 0) return 1'b1;
    return !((mv(n) >= VA + VF) && (mv(n) < VA + VF + VSW));
  endfunction
  function automatic logic [15:0] coord(input int c, input int l);
    return 16'h8000 | 16'(c << 4) | 16'(l);
  endfunction
  function automatic logic [15:0] pat_word(input int p, input int c, input int l);
    logic [15:0] w;
    logic [2:0]  idx;
    w = 16'h0;
    case (p)
      1: w = ((((c >> 1) ^ (l >> 1)) & 1) == 0) ? 16'hFFFF : 16'h0000;
      2: begin
        idx = 3'((c >> 1) & 7);
        w[15:11] = idx[2] ? 5'h1F : 5'h00;
        w[10:5]  = idx[1] ? 6'h3F : 6'h00;
        w[4:0]   = idx[0] ? 5'h1F : 5'h00;
      end
      3: w = (((c & 1) == 0) || ((l & 1) == 0)) ? 16'hFFFF : 16'h0000;
      default: w = 16'h0;
    endcase
    return w;
  endfunction

  // One clock: compare everything visible after edge k, then drive the next inputs
  task automatic step();
    int n, m;
    logic [15:0] e;
    @(negedge clk);
    k++;
    n = k - 1;
    m = k - 1 - (LAT + 1);
    if (mh(n) == 0 && mv(n) == 0) frame_pat = pat_sel;
    check("col", col, m_act(n) ? mh(n) : 0);
    check("lin", lin, m_act(n) ? mv(n) : 0);
    check("active", act, m_act(n));
    check("sof", sof, (mh(n) == 0 && mv(n) == 0));
    check("sol", sol, mh(n) == 0);
    check("hsync", hs, m_hs(m));
    check("vsync", vs, m_vs(m));
    check("den", den, m_act(m));
    for (int i = 0; i < 10; i++) begin
      if (vt[i].k == k) begin
        check("vec_col", col, vt[i].col);
        check("vec_lin", lin, vt[i].lin);
        check("vec_act", act, vt[i].act);
        check("vec_sof", sof, vt[i].sof);
        check("vec_sol", sol, vt[i].sol);
        check("vec_hs", hs, vt[i].hs);
        check("vec_vs", vs, vt[i].vs);
        check("vec_den", den, vt[i].den);
      end
    end
    if (den) begin
      if (sb.size() == 0) begin
        check("sb_empty", 1, 0);
      end else begin
        e = sb.pop_front();
        check("rgb", lcd_rgb, e);
      end
      if (cap_on && cap.size() < 4) cap.push_back(lcd_rgb);
    end else begin
      check("rgb_idle", lcd_rgb, 0);
    end
    if (win && m >= 0 && m < 2 * FT) begin
      if (!hs) hs_low++;
      if (!vs) vs_low++;
      if (den) den_hi++;
    end
    if (win && n < 2 * FT) begin
      if (sof) sof_cnt++;
      if (sol) sol_cnt++;
    end
    if (sof) begin
      if (last_sof >= 0) check("sof_period", k - last_sof, FT);
      last_sof = k;
    end
    if (sol) begin
      if (last_sol >= 0) check("sol_period", k - last_sol, HT);
      last_sol = k;
    end
    if (l0_act && !p_act0) last_act0 = k;
    if (l3_act && !p_act3) last_act3 = k;
    if (l0_den && !p_den0) check("lat0_den_delay", k - last_act0, 1);
    if (l3_den && !p_den3) check("lat3_den_delay", k - last_act3, 4);
    p_act0 = l0_act; p_den0 = l0_den; p_act3 = l3_act; p_den3 = l3_den;
    // Pixel source: presents {col,lin} one clock after the request
    rgb = prev_word;
    prev_word = coord(col, lin);
    if (m_act(n))
      sb.push_back((PAT_EN && frame_pat != 0) ? pat_word(frame_pat, mh(n), mv(n)) : coord(mh(n), mv(n)));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_col"}, col, 0);
    check({tag, "_lin"}, lin, 0);
    check({tag, "_active"}, act, 0);
    check({tag, "_sof"}, sof, 0);
    check({tag, "_sol"}, sol, 0);
    check({tag, "_hsync"}, hs, 1);
    check({tag, "_vsync"}, vs, 1);
    check({tag, "_den"}, den, 0);
    check({tag, "_rgb"}, lcd_rgb, 0);
    check({tag, "_lat0_den"}, l0_den, 0);
    check({tag, "_lat3_den"}, l3_den, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //        k    col lin act sof sol hs vs den
    vt[0] = '{  1, 0, 0, 1, 1, 1, 1, 1, 0};
    vt[1] = '{  3, 2, 0, 1, 0, 0, 1, 1, 1};
    vt[2] = '{  9, 0, 0, 0, 0, 0, 1, 1, 1};
    vt[3] = '{ 11, 0, 0, 0, 0, 0, 1, 1, 0};
    vt[4] = '{ 13, 0, 0, 0, 0, 0, 0, 1, 0};
    vt[5] = '{ 15, 0, 1, 1, 0, 1, 0, 1, 0};
    vt[6] = '{ 16, 1, 1, 1, 0, 0, 1, 1, 0};
    vt[7] = '{ 71, 0, 0, 0, 0, 1, 0, 1, 0};
    vt[8] = '{ 73, 0, 0, 0, 0, 0, 1, 0, 0};
    vt[9] = '{113, 0, 0, 1, 1, 1, 0, 1, 0};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;

    // Two full frames of passthrough
    win = 1'b1;
    repeat (2 * FT + LAT + 2) step();
    win = 1'b0;
    check("hsync_low_clocks", hs_low, 2 * VT * HSW);
    check("vsync_low_clocks", vs_low, 2 * VSW * HT);
    check("den_high_clocks", den_hi, 2 * HA * VA);
    check("sof_count", sof_cnt, 2);
    check("sol_count", sol_cnt, 2 * VT);

    // Mid-frame reset when the counters sit at hcnt 5, vcnt 2
    while ((k % FT) != (2 * HT + 5)) step();
    rst = 1'b1;
    pat_sel = 2'd1;
    @(negedge clk);
    check_reset_state("mid_rst");
    rst = 1'b0;
    k = 0;
    sb.delete();
    prev_word = 16'h0;
    rgb = 16'h0;
    last_sof = -1;
    last_sol = -1;
    p_act0 = 0; p_den0 = 0; p_act3 = 0; p_den3 = 0;
    cap_on = 1'b1;
    step();
    check("restart_sof", sof, 1);
    check("restart_col", col, 0);

    // Pattern selection changes mid-frame only take effect at the next frame start
    while (k < 50) step();
    pat_sel = 2'd2;
    while (k < FT + 50) step();
    pat_sel = 2'd3;
    while (k < 2 * FT + 50) step();
    pat_sel = 2'd0;
    while (k < 3 * FT + 20) step();

    check("cap_size", cap.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < cap.size())
        check("first_line_pixel", cap[i], PAT_EN ? ((i < 2) ? 16'hFFFF : 16'h0000) : coord(i, 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
